// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: show-ahead FIFO decoupling instruction fetch from decode, with one-cycle flush
module instruction_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_PushValid,
    output logic            o_PushReady,
    input  logic [XLEN-1:0] i_PushPC,
    input  logic [XLEN-1:0] i_PushNextPC,
    input  logic [31:0]     i_PushInstructionWord,
    input  logic            i_PushMisaligned,
    output logic            o_PopValid,
    input  logic            i_PopReady,
    output logic [XLEN-1:0] o_PopPC,
    output logic [XLEN-1:0] o_PopNextPC,
    output logic [31:0]     o_PopInstructionWord,
    output logic            o_PopMisaligned,
    input  logic            i_Flush,
    output logic [CW-1:0]   o_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * XLEN + 33;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_fetch_queue: DEPTH must be a power of two in 2..64");
    end

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign o_PushReady = count_q != CW'(DEPTH);
    assign o_PopValid  = count_q != '0;
    assign o_Count     = count_q;
    assign push        = i_PushValid & o_PushReady;
    assign pop         = o_PopValid & i_PopReady;
    assign {o_PopPC, o_PopNextPC, o_PopInstructionWord, o_PopMisaligned} = mem_q[rd_ptr_q];

    // Pointers wrap naturally at AW bits; count alone separates full from empty.
    always_comb begin
        rd_ptr_d = i_Flush ? '0 : pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = i_Flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = i_Flush ? '0 :
                   (push & ~pop) ? count_q + CW'(1) :
                   (pop & ~push) ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push & ~i_Flush & ~i_Reset)
            mem_q[wr_ptr_q] <= {i_PushPC, i_PushNextPC, i_PushInstructionWord, i_PushMisaligned};
    end

    a_count_bound: assert property (@(posedge i_Clock) count_q <= CW'(DEPTH));
    a_idle_stable: assert property (@(posedge i_Clock)
        !(i_Reset | i_Flush | push | pop) |=> $stable({rd_ptr_q, wr_ptr_q, count_q}));
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: three queue depths under shared stimulus, checked against a queue-based model
module tb_instruction_fetch_queue;
    logic        clk = 0;
    logic        rst, flush, push_valid, push_mis, pop_ready;
    logic [31:0] push_pc, push_npc, push_word;
    logic        pop_valid [3];
    logic        push_ready [3];
    logic        pop_mis [3];
    logic [31:0] pop_pc [3];
    logic [31:0] pop_npc [3];
    logic [31:0] pop_word [3];
    logic [7:0]  cnt [3];
    logic [96:0] mq [3][$];
    int          dep [3] = '{4, 2, 16};
    int          total = 0, passed = 0;
    bit          armed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 16;
        logic [$clog2(D):0] c;
        instruction_fetch_queue #(.XLEN(32), .DEPTH(D)) dut (
            .i_Clock(clk), .i_Reset(rst),
            .i_PushValid(push_valid), .o_PushReady(push_ready[g]),
            .i_PushPC(push_pc), .i_PushNextPC(push_npc),
            .i_PushInstructionWord(push_word), .i_PushMisaligned(push_mis),
            .o_PopValid(pop_valid[g]), .i_PopReady(pop_ready),
            .o_PopPC(pop_pc[g]), .o_PopNextPC(pop_npc[g]),
            .o_PopInstructionWord(pop_word[g]), .o_PopMisaligned(pop_mis[g]),
            .i_Flush(flush), .o_Count(c)
        );
        assign cnt[g] = 8'(c);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            automatic int  sz = mq[g].size();
            automatic bit  pu = push_valid && sz != dep[g];
            automatic bit  po = pop_ready && sz != 0;
            if (rst || flush) mq[g].delete();
            else begin
                if (po) void'(mq[g].pop_front());
                if (pu) mq[g].push_back({push_pc, push_npc, push_word, push_mis});
            end
        end
        if (rst) armed <= 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int g = 0; g < 3; g++) begin
                automatic int sz = mq[g].size();
                chk($sformatf("count[d%0d]", dep[g]), cnt[g], sz);
                chk($sformatf("pop_valid[d%0d]", dep[g]), pop_valid[g], sz != 0);
                chk($sformatf("push_ready[d%0d]", dep[g]), push_ready[g], sz != dep[g]);
                if (sz != 0) begin
                    chk($sformatf("head[d%0d]", dep[g]),
                        {pop_pc[g], pop_npc[g], pop_word[g], pop_mis[g]} == mq[g][0], 1);
                    if ({pop_pc[g], pop_npc[g], pop_word[g], pop_mis[g]} != mq[g][0])
                        $display("  head pc %0h expected pc %0h", pop_pc[g], mq[g][0][96:65]);
                end
            end
        end
    end

    task automatic step(input bit pv, input logic [31:0] pc, input bit pr,
                        input bit fl = 0, input bit rs = 0, input bit mis = 0);
        push_valid = pv; push_pc = pc; push_npc = pc + 4; push_word = pc ^ 32'h13;
        push_mis = mis; pop_ready = pr; flush = fl; rst = rs;
        @(negedge clk);
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_count", cnt[0], 0);
        chk("reset_ready", push_ready[0], 1);
        step(1, 0, 0);
        chk("t1_valid", pop_valid[0], 1);
        chk("t1_pc", pop_pc[0], 0);
        chk("t1_npc", pop_npc[0], 4);
        chk("t1_word", pop_word[0], 32'h13);
        chk("t1_count", cnt[0], 1);

        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 4 * i, 0);
        chk("t2_full_ready", push_ready[0], 0);
        chk("t2_full_count", cnt[0], 4);
        chk("t2_head0", pop_pc[0], 0);
        step(1, 32'h10, 1);
        chk("t2_refused_count", cnt[0], 3);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_head%0d", i), pop_pc[0], 4 * i);
            step(0, 0, 1);
        end
        chk("t2_empty", pop_valid[0], 0);

        step(0, 0, 0, 0, 1);
        step(1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("t3_head%0d", i), pop_pc[0], 4 * (i - 1));
            step(1, 4 * i, 1);
            chk($sformatf("t3_count%0d", i), cnt[0], 1);
        end

        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h20 + 4 * i, 0);
        step(1, 32'h40, 1, 1);
        chk("t4_count", cnt[0], 0);
        chk("t4_valid", pop_valid[0], 0);
        chk("t4_ready", push_ready[0], 1);
        step(1, 32'h80, 0);
        chk("t4_head", pop_pc[0], 32'h80);
        chk("t4_count1", cnt[0], 1);

        step(0, 0, 0, 0, 1);
        step(1, 32'h200, 0);
        step(1, 32'h204, 0);
        chk("t5_pre", cnt[0], 2);
        step(0, 0, 0, 0, 1);
        chk("t5_count", cnt[0], 0);
        chk("t5_valid", pop_valid[0], 0);
        chk("t5_ready", push_ready[0], 1);
        step(1, 32'h100, 0, 0, 0, 1);
        chk("t5_mis", pop_mis[0], 1);
        chk("t5_pc", pop_pc[0], 32'h100);
        step(0, 0, 1);
        chk("t5_drained", pop_valid[0], 0);

        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                step($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                     $urandom_range(0, 3) < ph, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0);
                push_word = $urandom;
            end
        end
        step(0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
